// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and macro-side bus of the two-port SRAM arbiter
// slave: arbiter view; master: clients plus macro read-data driver.
interface sram_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [1:0]             req_i;
  logic [1:0]             we_i;
  logic [1:0][ADDR_W-1:0] addr_i;
  logic [1:0][DATA_W-1:0] wdata_i;
  logic [1:0]             gnt_o;
  logic [1:0]             rvalid_o;
  logic [DATA_W-1:0]      rdata_o;
  logic                   sram_csb_o;
  logic                   sram_web_o;
  logic [ADDR_W-1:0]      sram_addr_o;
  logic [DATA_W-1:0]      sram_din_o;
  logic [DATA_W-1:0]      sram_dout_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, sram_dout_i,
    output gnt_o, rvalid_o, rdata_o, sram_csb_o, sram_web_o, sram_addr_o, sram_din_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, sram_dout_i,
    input  gnt_o, rvalid_o, rdata_o, sram_csb_o, sram_web_o, sram_addr_o, sram_din_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin sharing of one 1rw SRAM macro between two requesters
// Registered macro command, 2-deep read tag pipeline returning data to the issuer.
module sram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  sram_arbiter_if.slave     bus
);
  logic [1:0]        gnt;
  logic              win;
  logic              ptr_q, ptr_d;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              v1_q, v1_d, id1_q, id1_d;
  logic              v2_q, v2_d, id2_q, id2_d;

  always_comb begin
    gnt = 2'b00;
    if (rst_ni) begin
      unique case (bus.req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    win = gnt[1];

    // Pointer always lands on the requester that just lost (or sat idle).
    ptr_d = ptr_q;
    if (gnt[0]) ptr_d = 1'b1;
    else if (gnt[1]) ptr_d = 1'b0;

    csb_d  = 1'b1;
    web_d  = 1'b1;
    addr_d = addr_q;
    din_d  = din_q;
    if (|gnt) begin
      csb_d  = 1'b0;
      web_d  = ~bus.we_i[win];
      addr_d = bus.addr_i[win];
      din_d  = bus.wdata_i[win];
    end

    v1_d  = (|gnt) & ~bus.we_i[win];
    id1_d = win;
    v2_d  = v1_q;
    id2_d = id1_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q  <= 1'b0;
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
      v1_q   <= 1'b0;
      id1_q  <= 1'b0;
      v2_q   <= 1'b0;
      id2_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      csb_q  <= csb_d;
      web_q  <= web_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      v1_q   <= v1_d;
      id1_q  <= id1_d;
      v2_q   <= v2_d;
      id2_q  <= id2_d;
    end
  end

  // Second tag stage lines up with the cycle the macro presents dout.
  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = (v2_q && rst_ni) ? (id2_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata_o     = (v2_q && rst_ni) ? bus.sram_dout_i : '0;
  assign bus.sram_csb_o  = csb_q;
  assign bus.sram_web_o  = web_q;
  assign bus.sram_addr_o = addr_q;
  assign bus.sram_din_o  = din_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter with a 1rw macro model
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] mem [0:127];
  logic [31:0] exp_rd [0:3];

  sram_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  sram_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h100 + i;
    end else if (!bus.sram_csb_o) begin
      if (!bus.sram_web_o) mem[bus.sram_addr_o] <= bus.sram_din_o;
      else bus.sram_dout_i <= mem[bus.sram_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [6:0] a0, input logic [31:0] d0,
                       input logic [6:0] a1, input logic [31:0] d1);
    bus.req_i      = req;
    bus.we_i       = we;
    bus.addr_i[0]  = a0;
    bus.wdata_i[0] = d0;
    bus.addr_i[1]  = a1;
    bus.wdata_i[1] = d1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sram_dout_i = '0;
    idle();
    tick();
    // 1: reset, then idle
    drive(2'b11, 2'b00, 7'd1, 32'd0, 7'd2, 32'd0);
    @(negedge clk);
    chk("rst_gnt", {30'd0, bus.gnt_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("rst_csb", {31'd0, bus.sram_csb_o}, 32'd1);
    chk("rst_web", {31'd0, bus.sram_web_o}, 32'd1);
    chk("rst_addr", {25'd0, bus.sram_addr_o}, 32'd0);
    chk("rst_din", bus.sram_din_o, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_csb", {31'd0, bus.sram_csb_o}, 32'd1);
      chk("idle_web", {31'd0, bus.sram_web_o}, 32'd1);
      chk("idle_gnt", {30'd0, bus.gnt_o}, 32'd0);
      chk("idle_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
      tick();
    end

    // 2: req0 writes 42 to addr 5, then reads it back
    drive(2'b01, 2'b01, 7'd5, 32'd42, 7'd0, 32'd0);
    @(negedge clk);
    chk("t2_wr_gnt", {30'd0, bus.gnt_o}, 32'h1);
    tick();
    drive(2'b01, 2'b00, 7'd5, 32'd0, 7'd0, 32'd0);
    @(negedge clk);
    chk("t2_rd_gnt", {30'd0, bus.gnt_o}, 32'h1);
    chk("t2_wr_csb", {31'd0, bus.sram_csb_o}, 32'd0);
    chk("t2_wr_web", {31'd0, bus.sram_web_o}, 32'd0);
    chk("t2_wr_addr", {25'd0, bus.sram_addr_o}, 32'd5);
    chk("t2_wr_din", bus.sram_din_o, 32'd42);
    tick();
    idle();
    @(negedge clk);
    chk("t2_wr_norv", {30'd0, bus.rvalid_o}, 32'd0);
    chk("t2_rd_web", {31'd0, bus.sram_web_o}, 32'd1);
    chk("t2_rd_csb", {31'd0, bus.sram_csb_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t2_rvalid", {30'd0, bus.rvalid_o}, 32'h1);
    chk("t2_rdata", bus.rdata_o, 32'd42);
    chk("t2_csb_idle", {31'd0, bus.sram_csb_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("t2_rvalid_end", {30'd0, bus.rvalid_o}, 32'd0);
    tick();

    // 5: read granted, then reset in the next cycle (pointer currently favours req1)
    drive(2'b01, 2'b00, 7'd5, 32'd0, 7'd0, 32'd0);
    @(negedge clk);
    chk("t5_gnt", {30'd0, bus.gnt_o}, 32'h1);
    tick();
    rst_ni = 1'b0;
    idle();
    @(negedge clk);
    chk("t5_rst_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("t5_csb", {31'd0, bus.sram_csb_o}, 32'd1);
    chk("t5_rvalid_a", {30'd0, bus.rvalid_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_rvalid_b", {30'd0, bus.rvalid_o}, 32'd0);
    tick();

    // 3: both write continuously; first grant shows pointer back on req0
    drive(2'b11, 2'b11, 7'd1, 32'hA, 7'd2, 32'hB);
    @(negedge clk);
    chk("t3_gnt0", {30'd0, bus.gnt_o}, 32'h1);
    tick();
    @(negedge clk);
    chk("t3_gnt1", {30'd0, bus.gnt_o}, 32'h2);
    chk("t3_cmd1_csb", {31'd0, bus.sram_csb_o}, 32'd0);
    chk("t3_cmd1_addr", {25'd0, bus.sram_addr_o}, 32'd1);
    chk("t3_cmd1_din", bus.sram_din_o, 32'hA);
    tick();
    @(negedge clk);
    chk("t3_gnt2", {30'd0, bus.gnt_o}, 32'h1);
    chk("t3_cmd2_csb", {31'd0, bus.sram_csb_o}, 32'd0);
    chk("t3_cmd2_addr", {25'd0, bus.sram_addr_o}, 32'd2);
    chk("t3_cmd2_din", bus.sram_din_o, 32'hB);
    tick();
    @(negedge clk);
    chk("t3_gnt3", {30'd0, bus.gnt_o}, 32'h2);
    chk("t3_cmd3_addr", {25'd0, bus.sram_addr_o}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("t3_cmd4_csb", {31'd0, bus.sram_csb_o}, 32'd0);
    chk("t3_cmd4_addr", {25'd0, bus.sram_addr_o}, 32'd2);
    chk("t3_wr_norv", {30'd0, bus.rvalid_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_csb_idle", {31'd0, bus.sram_csb_o}, 32'd1);
    chk("t3_hold_addr", {25'd0, bus.sram_addr_o}, 32'd2);
    tick();

    // 4: req1 alone reads addr 0..3 back to back
    exp_rd[0] = 32'h100;
    exp_rd[1] = 32'hA;
    exp_rd[2] = 32'hB;
    exp_rd[3] = 32'h103;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(2'b10, 2'b00, 7'd0, 32'd0, 7'(i), 32'd0);
      else idle();
      @(negedge clk);
      chk($sformatf("t4_gnt%0d", i), {30'd0, bus.gnt_o}, (i < 4) ? 32'h2 : 32'h0);
      if (i >= 2 && i < 6) begin
        chk($sformatf("t4_rvalid%0d", i), {30'd0, bus.rvalid_o}, 32'h2);
        chk($sformatf("t4_rdata%0d", i), bus.rdata_o, exp_rd[i-2]);
      end else begin
        chk($sformatf("t4_rvalid%0d", i), {30'd0, bus.rvalid_o}, 32'h0);
      end
      tick();
    end

    // 6: req0 writes 7 to addr 9, req1 reads addr 9 the next cycle
    drive(2'b01, 2'b01, 7'd9, 32'd7, 7'd0, 32'd0);
    @(negedge clk);
    chk("t6_wr_gnt", {30'd0, bus.gnt_o}, 32'h1);
    tick();
    drive(2'b10, 2'b00, 7'd0, 32'd0, 7'd9, 32'd0);
    @(negedge clk);
    chk("t6_rd_gnt", {30'd0, bus.gnt_o}, 32'h2);
    tick();
    idle();
    @(negedge clk);
    chk("t6_rvalid_early", {30'd0, bus.rvalid_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t6_rvalid", {30'd0, bus.rvalid_o}, 32'h2);
    chk("t6_rdata", bus.rdata_o, 32'd7);
    tick();
    @(negedge clk);
    chk("t6_rvalid_end", {30'd0, bus.rvalid_o}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
